// File: rtl/tx_4b5b_921600_pkg.sv
// Shared definitions for the PC-to-line 4b5b transmitter.
//  - RX/TX FSM state encodings
//  - LED status codes for kill and framing-error conditions
//  - FRAME_BITS: line frame length (start + 2x5 code bits + stop)
//  - enc4b5b(): nibble -> 5-bit line code
package tx_4b5b_921600_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_KILL} tx_state_t;

  localparam logic [7:0] LED_KILL      = 8'hAA;
  localparam logic [7:0] LED_FRAME_ERR = 8'hBB;
  localparam int         FRAME_BITS    = 12;

  function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
    enc4b5b = 5'b11110;
    case (nib)
      4'h0: enc4b5b = 5'b11110;
      4'h1: enc4b5b = 5'b01001;
      4'h2: enc4b5b = 5'b10100;
      4'h3: enc4b5b = 5'b10101;
      4'h4: enc4b5b = 5'b01010;
      4'h5: enc4b5b = 5'b01011;
      4'h6: enc4b5b = 5'b01110;
      4'h7: enc4b5b = 5'b01111;
      4'h8: enc4b5b = 5'b10010;
      4'h9: enc4b5b = 5'b10011;
      4'hA: enc4b5b = 5'b10110;
      4'hB: enc4b5b = 5'b10111;
      4'hC: enc4b5b = 5'b11010;
      4'hD: enc4b5b = 5'b11011;
      4'hE: enc4b5b = 5'b11100;
      4'hF: enc4b5b = 5'b11101;
      default: enc4b5b = 5'b11110;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// PC-side 8N1 receiver with 2-flop input synchronizer.
// Ports:
//  CLK_50M    in   clock
//  RST_N      in   async active-low reset
//  hold       in   freezes the FSM and suppresses strobes (kill mode)
//  rxd        in   raw serial line from PC
//  rx_byte    out  received byte, valid with rx_valid
//  rx_valid   out  1-clk strobe: byte received with good stop bit
//  frame_err  out  1-clk strobe: stop bit sampled 0, byte dropped
module uart_byte_rx
  import tx_4b5b_921600_pkg::*;
#(
  parameter int PC_DIV = 54
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       hold,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(PC_DIV);

  rx_state_t       state, state_nxt;
  logic            rxd_s1, rxd_s2, rxd_s3;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            stop_seen;   // stop bit sampled; now waiting for line high
  logic            cnt_end;
  logic            fall;

  assign cnt_end = (cnt == '0);
  assign fall    = rxd_s3 & ~rxd_s2;

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) state <= RX_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (!hold) begin
      case (state)
        RX_IDLE:  if (fall) state_nxt = RX_START;
        RX_START: if (cnt_end) state_nxt = rxd_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (cnt_end && bit_idx == 3'd7) state_nxt = RX_STOP;
        RX_STOP:  if (stop_seen && rxd_s2) state_nxt = RX_IDLE;
        default:  state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_s3    <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_seen <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_s1    <= rxd;
      rxd_s2    <= rxd_s1;
      rxd_s3    <= rxd_s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!hold) begin
        case (state)
          RX_IDLE: begin
            stop_seen <= 1'b0;
            // half a bit from the edge lands the next sample mid start bit
            if (fall) cnt <= CW'(PC_DIV/2);
          end
          RX_START:
            if (cnt_end) begin
              cnt     <= CW'(PC_DIV-1);
              bit_idx <= '0;
            end else cnt <= cnt - 1'b1;
          RX_DATA:
            if (cnt_end) begin
              rx_byte <= {rxd_s2, rx_byte[7:1]};
              bit_idx <= bit_idx + 1'b1;
              cnt     <= CW'(PC_DIV-1);
            end else cnt <= cnt - 1'b1;
          RX_STOP:
            if (!stop_seen) begin
              if (cnt_end) begin
                stop_seen <= 1'b1;
                if (rxd_s2) rx_valid  <= 1'b1;
                else        frame_err <= 1'b1;
              end else cnt <= cnt - 1'b1;
            end
          default: ;
        endcase
      end
    end

endmodule

// File: rtl/tx_4b5b_921600.sv
// PC-to-line half of the 4b5b link. Receives 8N1 bytes from the PC,
// buffers them in a byte FIFO and sends each as a 12-bit line frame:
// start(0), enc(lo nibble), enc(hi nibble), stop(1), all LSB first.
// Optional build macro: ERR_KILL_EN -- any overrun/framing error freezes
// both FSMs with the line high and LED=8'hAA until RST_N.
// Ports:
//  CLK_50M        in   50 MHz clock
//  RST_N          in   async active-low reset
//  RS232_DCE_RXD  in   8N1 serial from PC
//  RS232_DTE_TXD  out  4b5b line frame out, idle high
//  LED            out  last byte received from PC, or error code
//  BUSY           out  frame in progress or FIFO non-empty
//  ERR_FRAME      out  sticky PC framing error
//  ERR_OVERRUN    out  sticky FIFO overrun
module tx_4b5b_921600
  import tx_4b5b_921600_pkg::*;
#(
  parameter int PC_DIV     = 54,
  parameter int LINE_DIV   = 46,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       RS232_DCE_RXD,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED,
  output logic       BUSY,
  output logic       ERR_FRAME,
  output logic       ERR_OVERRUN
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LINE_DIV);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_hold;

  tx_state_t  tx_state, tx_nxt;

  uart_byte_rx #(.PC_DIV(PC_DIV)) u_rx (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .hold      (rx_hold),
    .rxd       (RS232_DCE_RXD),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr)
  );

  // ---------------- FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop, overrun;
  logic [7:0]  rd_byte;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_byte    = mem[rptr[AW-1:0]];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push       = rx_valid & (~fifo_full | pop);
  assign overrun    = rx_valid & fifo_full & ~pop;

  always_ff @(posedge CLK_50M)
    if (push) mem[wptr[AW-1:0]] <= rx_byte;

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end

  // ---------------- line TX ----------------
  logic [FRAME_BITS-1:0] frame;
  logic [LW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic                  div_end, last_bit;

  assign div_end  = (div_cnt == LW'(LINE_DIV-1));
  assign last_bit = (bit_cnt == 4'(FRAME_BITS-1));

`ifdef ERR_KILL_EN
  logic kill_evt;
  assign kill_evt = overrun | rx_ferr;
  assign rx_hold  = (tx_state == TX_KILL);
`else
  assign rx_hold  = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) tx_state <= TX_IDLE;
    else        tx_state <= tx_nxt;

  always_comb begin
    tx_nxt = tx_state;
    pop    = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (!fifo_empty) begin
          pop    = 1'b1;
          tx_nxt = TX_SHIFT;
        end
      TX_SHIFT:
        // end of stop bit: chain straight into the next frame if one is queued
        if (div_end && last_bit) begin
          if (!fifo_empty) pop    = 1'b1;
          else             tx_nxt = TX_IDLE;
        end
      TX_KILL: ;
      default: tx_nxt = TX_IDLE;
    endcase
`ifdef ERR_KILL_EN
    if (kill_evt) begin
      tx_nxt = TX_KILL;
      pop    = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      frame   <= '1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      frame   <= {1'b1, enc4b5b(rd_byte[7:4]), enc4b5b(rd_byte[3:0]), 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (tx_state == TX_SHIFT) begin
      if (div_end) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 1'b1;
        frame   <= {1'b1, frame[FRAME_BITS-1:1]};
      end else div_cnt <= div_cnt + 1'b1;
    end

  // decoded from state so an async reset returns the line high immediately
  assign RS232_DTE_TXD = (tx_state == TX_SHIFT) ? frame[0] : 1'b1;
  assign BUSY          = (tx_state != TX_IDLE) | ~fifo_empty;

  // ---------------- status ----------------
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      LED         <= '0;
      ERR_FRAME   <= 1'b0;
      ERR_OVERRUN <= 1'b0;
    end else begin
      if (rx_valid) LED <= rx_byte;
      if (rx_ferr) begin
        LED       <= LED_FRAME_ERR;
        ERR_FRAME <= 1'b1;
      end
      if (overrun) ERR_OVERRUN <= 1'b1;
`ifdef ERR_KILL_EN
      if (kill_evt) LED <= LED_KILL;
`endif
    end

endmodule
